serial_add_sub: RTL



---
 rtl/serial_add_sub_pkg.sv | 18 +
 rtl/serial_add_sub_if.sv | 28 ++
 rtl/serial_add_sub_adder_slice.sv | 39 +++
 rtl/serial_add_sub.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN (signed-overflow tracking).
package serial_add_sub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  // Width of the slice index; a single-slice build still needs one bit.
  function automatic int idxWidth(input int numSlices);
    return (numSlices > 1) ? $clog2(numSlices) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result bundle between the datapath operand registers and the
// serial adder/subtractor. The master issues operations, the slave runs them.
interface serial_add_sub_if #(
  parameter int WIDTH = 16
);

  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Sub, A, B, Cin,
    input  S, Cout, Ovf, Busy, Done
  );

  modport slave (
    input  Start, Sub, A, B, Cin,
    output S, Cout, Ovf, Busy, Done
  );

endinterface

// File: rtl/serial_add_sub_adder_slice.sv
// Combinational SLICE-bit ripple of full-adder cells.
// With SERIAL_ADD_SUB_OVF_EN defined it also exports the carry into its top
// bit, which the parent uses to form signed overflow on the last slice.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cIn,
  output logic [SLICE-1:0] sum,
  output logic             cOut
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             cTop
`endif
);

  logic [SLICE:0] carry;

  // Ripple the carry through SLICE full-adder cells.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    sum   = '0;
    carry = '0;
    carry[0] = cIn;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cOut = carry[SLICE];

`ifdef SERIAL_ADD_SUB_OVF_EN
  assign cTop = carry[SLICE-1];
`endif

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed SLICE bits per
// clock with the carry held in a register between slices.
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN -- when defined, the carry
// into the MSB is tracked and Ovf reports signed overflow; otherwise Ovf is 0.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic             Clk,
  input logic             Rst,
  serial_add_sub_if.slave bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = idxWidth(N);

  stateT            state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] sumReg;
  logic [WIDTH-1:0] nextSum;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [SLICE-1:0] aSlice;
  logic [SLICE-1:0] bSlice;
  logic [SLICE-1:0] sliceSum;
  logic             sliceCout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             sliceCtop;
`endif

  logic accept;
  logic lastSlice;

  // A new operation is taken whenever the block is not running.
  assign accept    = bus.Start && (state != RUN);
  assign lastSlice = (state == RUN) && (idx == IDX_W'(N - 1));

  // Select the current slice and merge its sum into the partial result.
  always_comb begin
    aSlice  = aReg[int'(idx) * SLICE +: SLICE];
    bSlice  = bReg[int'(idx) * SLICE +: SLICE];
    nextSum = sumReg;
    nextSum[int'(idx) * SLICE +: SLICE] = sliceSum;
  end

  adder_slice #(
    .SLICE (SLICE)
  ) sliceAdder (
    .a    (aSlice),
    .b    (bSlice),
    .cIn  (carry),
    .sum  (sliceSum),
    .cOut (sliceCout)
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    .cTop (sliceCtop)
`endif
  );

  // Control FSM with registered Busy/Done handshake outputs.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state    <= IDLE;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      bus.Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= RUN;
            bus.Busy <= 1'b1;
          end
        end
        RUN: begin
          if (lastSlice) begin
            state    <= DONE;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b1;
          end
        end
        DONE: begin
          if (accept) begin
            state    <= RUN;
            bus.Busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture, slice-by-slice accumulation and result registers.
  always_ff @(posedge Clk) begin
    // NOTE: the operand and partial-sum registers are cleared by reset too,
    // so an aborted operation leaves nothing behind.
    if (Rst) begin
      aReg     <= '0;
      bReg     <= '0;
      sumReg   <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      bus.S    <= '0;
      bus.Cout <= 1'b0;
    end else if (accept) begin
      aReg   <= bus.A;
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      bReg   <= bus.Sub ? ~bus.B : bus.B;
      carry  <= bus.Sub | bus.Cin;
      sumReg <= '0;
      idx    <= '0;
    end else if (state == RUN) begin
      sumReg <= nextSum;
      carry  <= sliceCout;
      if (lastSlice) begin
        bus.S    <= nextSum;
        bus.Cout <= sliceCout;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.Ovf <= 1'b0;
    end else if (lastSlice) begin
      bus.Ovf <= sliceCtop ^ sliceCout;
    end
  end
`else
  assign bus.Ovf = 1'b0;
`endif

endmodule
